simple_median_top: RTL and testbench
====================================

// Module: simple_median_top
// PURPOSE
//  Binary-image 3x3 median (majority) filter with activity wake-up.
//  - Host loads a 240x180 1-bit image into internal RAM, then raises start.
//  - Block scans every interior pixel and streams each filtered bit with its
//    address to an external median memory.
//  - It counts filtered '1' pixels and flags wakeUp when that count exceeds
//    threshold.
// PARAMETERS
//  IMG_W   240  image width; x address range 0..IMG_W-1
//  IMG_H   180  image height; y address range 0..IMG_H-1
//  ADDR_W  8    width of x/y address ports
//  THR_W   13   width of threshold
//  CNT_W   12   width of internal activeWindows counter
//  MAJ     5    ones in a 3x3 window needed for output 1
// PORTS
//  clk                   in   1       system clock, all logic on rising edge
//  reset                 in   1       synchronous, active-high reset
//  writeMem              in   1       image-load write enable
//  xAddressIn            in   ADDR_W  load x address
//  yAddressIn            in   ADDR_W  load y address
//  dataIn                in   1       load pixel value
//  start                 in   1       level request to filter loaded image
//  threshold             in   THR_W   wake-up threshold, unsigned
//  writeMedianMem        out  1       1-cycle strobe: filtered pixel valid
//  writeMedianData       out  1       filtered pixel value
//  xAddressOutMedianMem  out  ADDR_W  x of filtered pixel (window centre)
//  yAddressOutMedianMem  out  ADDR_W  y of filtered pixel (window centre)
//  fullImageDone         out  1       level: whole image filtered
//  wakeUp                out  1       level: done and activeWindows > threshold
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; scan counters and activeWindows 0.
//    Image RAM contents are not cleared. Reset mid-scan aborts to IDLE.
//  - Image RAM: IMG_W*IMG_H bits, single port, synchronous read, 1-cycle latency.
//  - Load: in IDLE, writeMem=1 writes dataIn to pixel (xAddressIn,yAddressIn)
//    on each clock. Writes with out-of-range addresses are dropped.
//    writeMem is ignored in every state other than IDLE.
//  - FSM IDLE->SCAN: start=1 and writeMem=0 sampled in IDLE.
//  - Scan order: x = 1..IMG_W-2 outer loop, y = 1..IMG_H-2 inner loop. This
//    gives 238*178 = 42364 windows. Border pixels produce no output.
//  - Per window, 11 cycles:
//    - Cycles 1-9: read the 9 neighbours (x-1..x+1, y-1..y+1) in order.
//    - The ones count accumulates one cycle behind each read (4-bit sum).
//    - Cycle 10: last data is added.
//    - Cycle 11: writeMedianMem=1 for exactly this cycle.
//      - writeMedianData = (sum >= MAJ).
//      - Address outputs = centre (x,y).
//  - First strobe is in the 11th cycle after the edge that samples start.
//    Successive strobes are exactly 11 cycles apart.
//  - Outside the strobe cycle, writeMedianMem=0. Data and address outputs
//    hold their last values.
//  - activeWindows increments on every strobe with data 1. It saturates at
//    2^CNT_W-1 = 4095 and does not wrap.
//  - After the strobe for (IMG_W-2, IMG_H-2), the next cycle enters DONE.
//  - DONE:
//    - fullImageDone = 1.
//    - wakeUp = ({1'b0,activeWindows} > threshold), unsigned 13-bit compare.
//    - Equality gives wakeUp = 0.
//    - Outputs hold while start stays 1; there is no automatic re-run.
//  - DONE->IDLE when start=0. This clears fullImageDone, wakeUp and
//    activeWindows. A new start high then re-runs the scan.
//  - A start pulse shorter than one clock but sampled high is sufficient.
//    start is ignored during SCAN.
// TESTING
//  - All-zero image, threshold=50, start held 1:
//    -> 42364 strobes, all data 0, first at (1,1), last at (238,178).
//    -> fullImageDone=1, wakeUp=0.
//  - All-ones image, threshold=50:
//    -> every strobe data 1; activeWindows saturates at 4095; wakeUp=1.
//  - Single 1 at (100,100), rest 0 -> all outputs 0 (isolated pixel removed).
//  - Rows y=49..51 all 1, rest 0, threshold=237:
//    -> 238*1 strobes with data 1, centred at y=50 (plus y=49/51 rows get 6 ones
//       only where a full 3-wide window fits: all 3 rows -> 714 ones).
//    -> wakeUp=1. Repeat with threshold=714 -> wakeUp=0 (equality).
//  - Timing/reset: start sampled at edge k -> strobe in cycle k+11 with (1,1),
//    next in cycle k+22 with (1,2).
//    -> reset asserted mid-scan: next cycle all outputs 0, no further strobes
//       until a new start.
//  - Re-run: drop start after DONE -> fullImageDone=0, wakeUp=0.
//    Raise start again -> identical output stream.

Source files
------------

// File: rtl/simple_median_top.sv
// Binary-image 3x3 majority filter: scans every interior pixel of a loaded
// 1-bit image, streams filtered bits out and raises wakeUp on enough activity.
module simple_median_top #(
  parameter int IMG_W  = 240,
  parameter int IMG_H  = 180,
  parameter int ADDR_W = 8,
  parameter int THR_W  = 13,
  parameter int CNT_W  = 12,
  parameter int MAJ    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeMem,
  input  logic [ADDR_W-1:0] xAddressIn,
  input  logic [ADDR_W-1:0] yAddressIn,
  input  logic              dataIn,
  input  logic              start,
  input  logic [THR_W-1:0]  threshold,
  output logic              writeMedianMem,
  output logic              writeMedianData,
  output logic [ADDR_W-1:0] xAddressOutMedianMem,
  output logic [ADDR_W-1:0] yAddressOutMedianMem,
  output logic              fullImageDone,
  output logic              wakeUp
);

  localparam int PIX    = IMG_W * IMG_H;
  localparam int RAM_AW = $clog2(PIX);
  localparam int CMP_W  = THR_W + CNT_W;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             r_state, w_nextState;
  logic [3:0]         r_phase;
  logic [3:0]         r_sum;
  logic [ADDR_W-1:0]  r_x, r_y;
  logic [CNT_W-1:0]   r_activeWindows;
  logic               r_ram [0:PIX-1];
  logic               r_rdData;
  logic               r_strobe, r_data;
  logic [ADDR_W-1:0]  r_xOut, r_yOut;

  logic [3:0]         w_sumFinal;
  logic               w_median;
  logic               w_lastWindow;
  logic               w_startScan;
  logic               w_inRange;
  logic               w_writeEn;
  logic [1:0]         w_dx, w_dy;
  logic [RAM_AW-1:0]  w_rdAddr, w_wrAddr, w_ramAddr;
  logic [CMP_W-1:0]   w_activeWide, w_thrWide;

  assign w_startScan  = (r_state == IDLE) && start && !writeMem;
  assign w_lastWindow = (r_x == ADDR_W'(IMG_W - 2)) && (r_y == ADDR_W'(IMG_H - 2));
  assign w_inRange    = (xAddressIn < ADDR_W'(IMG_W)) && (yAddressIn < ADDR_W'(IMG_H));
  assign w_writeEn    = (r_state == IDLE) && writeMem && w_inRange;

  // Phase 0..8 walks the window row by row, top-left to bottom-right.
  always_comb begin
    w_dx = 2'd0;
    w_dy = 2'd0;
    case (r_phase)
      4'd1:    w_dx = 2'd1;
      4'd2:    w_dx = 2'd2;
      4'd3:    w_dy = 2'd1;
      4'd4:    begin w_dx = 2'd1; w_dy = 2'd1; end
      4'd5:    begin w_dx = 2'd2; w_dy = 2'd1; end
      4'd6:    w_dy = 2'd2;
      4'd7:    begin w_dx = 2'd1; w_dy = 2'd2; end
      4'd8:    begin w_dx = 2'd2; w_dy = 2'd2; end
      default: ;
    endcase
  end

  assign w_rdAddr  = (RAM_AW'(r_y) + RAM_AW'(w_dy) - RAM_AW'(1)) * RAM_AW'(IMG_W)
                   + RAM_AW'(r_x) + RAM_AW'(w_dx) - RAM_AW'(1);
  assign w_wrAddr  = RAM_AW'(yAddressIn) * RAM_AW'(IMG_W) + RAM_AW'(xAddressIn);
  assign w_ramAddr = (r_state == SCAN) ? w_rdAddr : w_wrAddr;

  // Single-port image RAM; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_writeEn)
      r_ram[w_ramAddr] <= dataIn;
    r_rdData <= r_ram[w_ramAddr];
  end

  assign w_sumFinal = r_sum + {3'b000, r_rdData};
  assign w_median   = (w_sumFinal >= 4'(MAJ));

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start && !writeMem) w_nextState = SCAN;
      SCAN:    if (r_phase == 4'd10 && w_lastWindow) w_nextState = DONE;
      DONE:    if (!start) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so the sum trails the reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase         <= 4'd0;
      r_sum           <= 4'd0;
      r_x             <= '0;
      r_y             <= '0;
      r_activeWindows <= '0;
      r_strobe        <= 1'b0;
      r_data          <= 1'b0;
      r_xOut          <= '0;
      r_yOut          <= '0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_startScan) begin
            r_x             <= ADDR_W'(1);
            r_y             <= ADDR_W'(1);
            r_phase         <= 4'd0;
            r_sum           <= 4'd0;
            r_activeWindows <= '0;
          end
        end
        SCAN: begin
          if (r_phase >= 4'd1 && r_phase <= 4'd8)
            r_sum <= w_sumFinal;
          if (r_phase == 4'd9) begin
            r_strobe <= 1'b1;
            r_data   <= w_median;
            r_xOut   <= r_x;
            r_yOut   <= r_y;
            if (w_median && (r_activeWindows != {CNT_W{1'b1}}))
              r_activeWindows <= r_activeWindows + 1'b1;
          end
          if (r_phase == 4'd10) begin
            r_phase <= 4'd0;
            r_sum   <= 4'd0;
            if (!w_lastWindow) begin
              if (r_y == ADDR_W'(IMG_H - 2)) begin
                r_y <= ADDR_W'(1);
                r_x <= r_x + 1'b1;
              end else begin
                r_y <= r_y + 1'b1;
              end
            end
          end else begin
            r_phase <= r_phase + 4'd1;
          end
        end
        DONE: begin
          if (!start)
            r_activeWindows <= '0;
        end
        default: ;
      endcase
    end
  end

  assign w_activeWide = CMP_W'(r_activeWindows);
  assign w_thrWide    = CMP_W'(threshold);

  assign writeMedianMem       = r_strobe;
  assign writeMedianData      = r_data;
  assign xAddressOutMedianMem = r_xOut;
  assign yAddressOutMedianMem = r_yOut;
  assign fullImageDone        = (r_state == DONE);
  assign wakeUp               = (r_state == DONE) && (w_activeWide > w_thrWide);

endmodule

// File: tb/tb_simple_median_top.sv
// Directed bench for simple_median_top on a reduced 16x10 image (112 windows)
// with a narrow activity counter so saturation is reachable quickly.
module tb_simple_median_top;

  localparam int W  = 16;
  localparam int H  = 10;
  localparam int AW = 8;
  localparam int TW = 7;
  localparam int CW = 6;
  localparam int WINDOWS = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          reset;
  logic          writeMem;
  logic [AW-1:0] xAddressIn, yAddressIn;
  logic          dataIn;
  logic          start;
  logic [TW-1:0] threshold;
  logic          writeMedianMem, writeMedianData;
  logic [AW-1:0] xAddressOutMedianMem, yAddressOutMedianMem;
  logic          fullImageDone, wakeUp;

  simple_median_top #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .THR_W(TW), .CNT_W(CW), .MAJ(5)
  ) dut (
    .clk(clk), .reset(reset), .writeMem(writeMem),
    .xAddressIn(xAddressIn), .yAddressIn(yAddressIn), .dataIn(dataIn),
    .start(start), .threshold(threshold),
    .writeMedianMem(writeMedianMem), .writeMedianData(writeMedianData),
    .xAddressOutMedianMem(xAddressOutMedianMem),
    .yAddressOutMedianMem(yAddressOutMedianMem),
    .fullImageDone(fullImageDone), .wakeUp(wakeUp)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int edgeCount  = 0;
  int startEdge  = 0;
  int lastEdge   = 0;
  int strobes    = 0;
  int ones       = 0;
  int expX       = 1;
  int expY       = 1;
  bit img [0:H-1][0:W-1];

  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expMedian(input int x, input int y);
    int s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        s += int'(img[y+dy][x+dx]);
    return (s >= 5) ? 32'd1 : 32'd0;
  endfunction

  // Follows every strobe against the expected scan order and window majority.
  always @(negedge clk) begin
    if (writeMedianMem) begin
      strobes++;
      if (writeMedianData) ones++;
      if (expX > W - 2) begin
        checkOutput("extraStrobe", 32'd1, 32'd0);
      end else begin
        checkOutput("data", 32'(writeMedianData), expMedian(expX, expY));
        checkOutput("xOut", 32'(xAddressOutMedianMem), 32'(expX));
        checkOutput("yOut", 32'(yAddressOutMedianMem), 32'(expY));
        if (strobes == 1)
          checkOutput("firstLatency", 32'(edgeCount - startEdge), 32'd10);
        else
          checkOutput("strobeGap", 32'(edgeCount - lastEdge), 32'd11);
        if (expY == H - 2) begin
          expY = 1;
          expX++;
        end else begin
          expY++;
        end
      end
      lastEdge = edgeCount;
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".strobe"}, 32'(writeMedianMem), 32'd0);
    checkOutput({tag, ".data"}, 32'(writeMedianData), 32'd0);
    checkOutput({tag, ".x"}, 32'(xAddressOutMedianMem), 32'd0);
    checkOutput({tag, ".y"}, 32'(yAddressOutMedianMem), 32'd0);
    checkOutput({tag, ".done"}, 32'(fullImageDone), 32'd0);
    checkOutput({tag, ".wake"}, 32'(wakeUp), 32'd0);
  endtask

  task automatic writePixel(input int x, input int y, input bit v);
    @(negedge clk);
    writeMem   = 1'b1;
    xAddressIn = AW'(x);
    yAddressIn = AW'(y);
    dataIn     = v;
    @(negedge clk);
    writeMem = 1'b0;
    dataIn   = 1'b0;
  endtask

  task automatic loadImage();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        @(negedge clk);
        writeMem   = 1'b1;
        xAddressIn = AW'(x);
        yAddressIn = AW'(y);
        dataIn     = img[y][x];
      end
    @(negedge clk);
    writeMem = 1'b0;
    dataIn   = 1'b0;
  endtask

  task automatic fillImage(input bit v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = v;
  endtask

  // Raises start (held), optionally pokes the RAM mid-scan, waits for DONE.
  task automatic applyStimulus(input int thr, input bit inject);
    int n = 0;
    threshold = TW'(thr);
    strobes = 0;
    ones    = 0;
    expX    = 1;
    expY    = 1;
    @(negedge clk);
    start     = 1'b1;
    startEdge = edgeCount + 1;
    if (inject) begin
      repeat (3) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
        writeMem   = 1'b1;
        xAddressIn = AW'(9 + i % 3);
        yAddressIn = AW'(4 + i / 3);
        dataIn     = 1'b1;
        @(negedge clk);
      end
      writeMem = 1'b0;
      dataIn   = 1'b0;
    end
    while (!fullImageDone && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneSeen", 32'(fullImageDone), 32'd1);
    checkOutput("doneLatency", 32'(edgeCount - lastEdge), 32'd1);
    checkOutput("strobeCount", 32'(strobes), 32'(WINDOWS));
    checkOutput("lastX", 32'(xAddressOutMedianMem), 32'd14);
    checkOutput("lastY", 32'(yAddressOutMedianMem), 32'd8);
    checkOutput("strobeLowInDone", 32'(writeMedianMem), 32'd0);
  endtask

  task automatic dropStart(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".done"}, 32'(fullImageDone), 32'd0);
    checkOutput({tag, ".wake"}, 32'(wakeUp), 32'd0);
  endtask

  initial begin
    reset = 1'b1; writeMem = 1'b0; xAddressIn = '0; yAddressIn = '0;
    dataIn = 1'b0; start = 1'b0; threshold = '0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;

    // All-zero image, writes attempted during the scan must be ignored.
    fillImage(1'b0);
    loadImage();
    applyStimulus(0, 1'b1);
    checkOutput("zeros.ones", 32'(ones), 32'd0);
    checkOutput("zeros.wake", 32'(wakeUp), 32'd0);
    dropStart("zeros.drop");

    // All ones: 112 ones saturates the 6-bit counter at 63.
    fillImage(1'b1);
    loadImage();
    applyStimulus(62, 1'b0);
    checkOutput("ones.ones", 32'(ones), 32'd112);
    checkOutput("ones.wake62", 32'(wakeUp), 32'd1);
    @(negedge clk);
    threshold = TW'(63);
    #1;
    checkOutput("ones.wake63", 32'(wakeUp), 32'd0);
    dropStart("ones.drop");

    // Sub-cycle start pulse, then reset mid-scan.
    strobes = 0; ones = 0; expX = 1; expY = 1;
    @(negedge clk);
    #4 start = 1'b1;
    startEdge = edgeCount + 1;
    #2 start = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("pulse.strobes", 32'(strobes), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    checkIdleOutputs("midReset");
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("midReset.noStrobe", 32'(strobes), 32'd3);
    checkOutput("midReset.idle", 32'(fullImageDone), 32'd0);

    // Isolated pixel disappears.
    fillImage(1'b0);
    img[5][7] = 1'b1;
    loadImage();
    applyStimulus(0, 1'b0);
    checkOutput("single.ones", 32'(ones), 32'd0);
    dropStart("single.drop");

    // Rows 4..6 set: 3 full rows of 14 ones; out-of-range writes dropped.
    fillImage(1'b0);
    for (int x = 0; x < W; x++) begin
      img[4][x] = 1'b1; img[5][x] = 1'b1; img[6][x] = 1'b1;
    end
    loadImage();
    writePixel(20, 2, 1'b1);
    writePixel(21, 2, 1'b1);
    applyStimulus(41, 1'b0);
    checkOutput("rows.ones", 32'(ones), 32'd42);
    checkOutput("rows.wake41", 32'(wakeUp), 32'd1);
    @(negedge clk);
    threshold = TW'(42);
    #1;
    checkOutput("rows.wake42", 32'(wakeUp), 32'd0);
    dropStart("rows.drop");
    applyStimulus(42, 1'b0);
    checkOutput("rerun.ones", 32'(ones), 32'd42);
    checkOutput("rerun.wake42", 32'(wakeUp), 32'd0);
    dropStart("rerun.drop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
